data_uart_packetizer: RTL and testbench
=======================================

// Module: data_uart_packetizer
// PURPOSE
//  Drains 16-bit capture words from the transfer FIFO at the DataCapture output and frames them into byte packets.
//  Packets go to the single-byte UART transmitter. Frame: 0xA5 header, words MSB-first, word-count byte, XOR checksum.
//  Sits in the slow clock domain between the capture path's transfer FIFO (read side) and the UART TX.
// PARAMETERS
//  MAX_WORDS     64   max words per packet, 1..255; packet closes when reached
//  GAP_CYCLES    256  idle cycles with FIFO empty that close an open packet, >=1
//  VALID_TIMEOUT 8    cycles allowed from fifoRead to fifoValid before error, >=2
//  HEADER        8'hA5 packet start byte
// PORTS
//  clk         in  1  slow system clock; same clock as the transfer FIFO and the UART
//  rst_n       in  1  asynchronous, active-low reset
//  fifoReady   in  1  transfer FIFO not empty
//  fifoValid   in  1  fifoData valid, one cycle after fifoRead (standard-read FIFO)
//  fifoData    in  16 FIFO read data
//  fifoRead    out 1  FIFO read enable, single-cycle pulse per word
//  txBusy      in  1  UART busy; rises the cycle after txStart, high until byte sent
//  txStart     out 1  one-cycle request to send txData
//  txData      out 8  byte to send; stable while txStart high
//  pktActive   out 1  high from HEADER send until checksum accepted
//  timeoutErr  out 1  sticky; set on VALID_TIMEOUT expiry, cleared only by reset
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; fifoRead, txStart, pktActive, timeoutErr = 0; txData = 0; counters, checksum = 0.
//  Byte send: pulse txStart only when txBusy=0 and txStart was 0 last cycle (no back-to-back pulses).
//   A byte counts as accepted on its txStart cycle.
//  Checksum: 8-bit XOR of every byte after HEADER, including count byte; checksum byte itself excluded.
//  State machine:
//   IDLE: fifoReady=1 -> SEND_HDR (clear wordCnt, csum, gapCnt).
//   SEND_HDR: send HEADER, pktActive<=1 -> FETCH.
//   FETCH: assert fifoRead for exactly one cycle -> WAIT_VALID (tmoCnt=0).
//   WAIT_VALID: fifoValid=1 -> latch fifoData, wordCnt++ -> SEND_HI.
//    tmoCnt reaches VALID_TIMEOUT -> timeoutErr<=1 -> SEND_CNT; word is dropped, wordCnt unchanged.
//   SEND_HI: send data[15:8] -> SEND_LO.  SEND_LO: send data[7:0] -> NEXT.
//   NEXT: wordCnt==MAX_WORDS -> SEND_CNT.
//    Else fifoReady=1 -> FETCH (gapCnt=0).
//    Else gapCnt++; gapCnt reaches GAP_CYCLES -> SEND_CNT.
//   SEND_CNT: send wordCnt[7:0] -> SEND_CSUM.
//   SEND_CSUM: send csum; pktActive<=0 -> IDLE.
//  Zero-word packet (timeout on first word) is legal: A5 00 00.
//  fifoRead is never asserted outside FETCH, so there is at most one read outstanding.
//  Late fifoValid after timeout is ignored: it is not captured and does not affect state.
//  fifoRead must never be asserted while fifoReady=0 (FETCH entered only with fifoReady=1).
//  Reset mid-packet: immediate abort, no trailer sent; downstream resyncs on the next HEADER.
//  Latency: fifoReady rise in IDLE -> first txStart (HEADER) on the next cycle if txBusy=0.
// TESTING
//  1) FIFO holds 0x1234, then empties; GAP_CYCLES=4.
//     Expected: bytes A5 12 34 01 27 (0x12^0x34^0x01=0x27); pktActive falls after 27.
//  2) MAX_WORDS=2; FIFO holds 0x0001, 0x0002, 0x0003.
//     Expected packet 1: A5 00 01 00 02 02 01. Expected packet 2: A5 00 03 01 02.
//  3) fifoValid held low after fifoRead, VALID_TIMEOUT=8.
//     Expected: timeoutErr=1 eight cycles after the read; bytes A5 00 00; timeoutErr stays set afterwards.
//  4) txBusy held high 20 cycles per byte.
//     Expected: no txStart while busy; no back-to-back txStart; txData stable during every pulse; byte order unchanged.
//  5) rst_n low during SEND_LO.
//     Expected: all outputs 0 asynchronously; after release, the next FIFO word starts a fresh A5 packet.
//  6) Random words, random txBusy, 1000 packets.
//     Expected: scoreboard matches every frame and checksum; one fifoRead pulse per word; never read while fifoReady=0.

Source files
------------

// File: rtl/data_uart_packetizer.sv
// ----------------------------------------------------------------------------
// data_uart_packetizer
//
// Drains 16-bit capture words from the transfer FIFO read side and frames them
// into byte packets for a single-byte UART transmitter:
//
//   HEADER, {word[15:8], word[7:0]} x N, N[7:0], XOR checksum
//
// The checksum is the XOR of every byte after HEADER, including the count byte.
// A packet closes when MAX_WORDS words have been sent, when the FIFO stays
// empty for GAP_CYCLES cycles between words, or when a read is not answered by
// fifoValid in time. A timeout drops the word, sets the sticky timeoutErr and
// still emits a well-formed trailer, so a timeout on the first word yields
// HEADER 00 00.
//
// Ports
//   clk        slow system clock (shared with the transfer FIFO and the UART)
//   rst_n      asynchronous active-low reset; aborts any packet in flight
//   fifoReady  transfer FIFO not empty
//   fifoValid  fifoData valid, one cycle after fifoRead
//   fifoData   FIFO read data
//   fifoRead   FIFO read enable, one single-cycle pulse per word
//   txBusy     UART busy, rises the cycle after txStart
//   txStart    one-cycle request to send txData
//   txData     byte to send, stable while txStart is high
//   pktActive  high from the HEADER send until the checksum send
//   timeoutErr sticky read-timeout flag, cleared only by reset
// ----------------------------------------------------------------------------
module data_uart_packetizer #(
  parameter int         MAX_WORDS     = 64,
  parameter int         GAP_CYCLES    = 256,
  parameter int         VALID_TIMEOUT = 8,
  parameter logic [7:0] HEADER        = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fifoReady,
  input  logic        fifoValid,
  input  logic [15:0] fifoData,
  output logic        fifoRead,
  input  logic        txBusy,
  output logic        txStart,
  output logic [7:0]  txData,
  output logic        pktActive,
  output logic        timeoutErr
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int TMO_W = $clog2(VALID_TIMEOUT + 1);

  localparam logic [7:0]       MAX_W8   = 8'(MAX_WORDS);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(VALID_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE,
    SEND_HDR,
    FETCH,
    WAIT_VALID,
    SEND_HI,
    SEND_LO,
    NEXT,
    SEND_CNT,
    SEND_CSUM
  } state_t;

  state_t           state;
  logic [7:0]       word_cnt;
  logic [7:0]       csum;
  logic [GAP_W-1:0] gap_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [15:0]      word_q;
  logic             can_send;

  // A byte may be issued only when the UART is idle and no request went out
  // last cycle: txBusy lags txStart by one cycle, so the txStart term is what
  // prevents a second pulse before the UART has reacted to the first.
  assign can_send = !txBusy && !txStart;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      fifoRead   <= 1'b0;
      txStart    <= 1'b0;
      txData     <= '0;
      pktActive  <= 1'b0;
      timeoutErr <= 1'b0;
      word_cnt   <= '0;
      csum       <= '0;
      gap_cnt    <= '0;
      tmo_cnt    <= '0;
      word_q     <= '0;
    end else begin
      // Both strobes are single-cycle; they are raised only on the
      // transitions below.
      fifoRead <= 1'b0;
      txStart  <= 1'b0;

      case (state)
        IDLE: begin
          if (fifoReady) begin
            word_cnt <= '0;
            csum     <= '0;
            gap_cnt  <= '0;
            // Issue the header straight away when the UART is free so the
            // first byte leaves one cycle after fifoReady is seen.
            if (can_send) begin
              txStart   <= 1'b1;
              txData    <= HEADER;
              pktActive <= 1'b1;
              fifoRead  <= 1'b1;
              state     <= FETCH;
            end else begin
              state <= SEND_HDR;
            end
          end
        end

        SEND_HDR: begin
          // The FIFO cannot drain without our reads, so fifoReady seen in
          // IDLE still holds here and the fetch below is safe.
          if (can_send) begin
            txStart   <= 1'b1;
            txData    <= HEADER;
            pktActive <= 1'b1;
            fifoRead  <= 1'b1;
            state     <= FETCH;
          end
        end

        FETCH: begin
          // fifoRead is high during this state. tmo_cnt holds the number of
          // cycles elapsed since that pulse.
          tmo_cnt <= TMO_W'(1);
          state   <= WAIT_VALID;
        end

        WAIT_VALID: begin
          // fifoValid wins over an expiring timer in the same cycle.
          if (fifoValid) begin
            word_q   <= fifoData;
            word_cnt <= word_cnt + 8'd1;
            state    <= SEND_HI;
          end else if (tmo_cnt == TMO_LAST) begin
            timeoutErr <= 1'b1;
            state      <= SEND_CNT;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        SEND_HI: begin
          if (can_send) begin
            txStart <= 1'b1;
            txData  <= word_q[15:8];
            csum    <= csum ^ word_q[15:8];
            state   <= SEND_LO;
          end
        end

        SEND_LO: begin
          if (can_send) begin
            txStart <= 1'b1;
            txData  <= word_q[7:0];
            csum    <= csum ^ word_q[7:0];
            state   <= NEXT;
          end
        end

        NEXT: begin
          if (word_cnt == MAX_W8) begin
            state <= SEND_CNT;
          end else if (fifoReady) begin
            gap_cnt  <= '0;
            fifoRead <= 1'b1;
            state    <= FETCH;
          end else if (gap_cnt == GAP_LAST) begin
            state <= SEND_CNT;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        SEND_CNT: begin
          if (can_send) begin
            txStart <= 1'b1;
            txData  <= word_cnt;
            csum    <= csum ^ word_cnt;
            state   <= SEND_CSUM;
          end
        end

        SEND_CSUM: begin
          if (can_send) begin
            txStart   <= 1'b1;
            txData    <= csum;
            pktActive <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_uart_packetizer.sv
// ----------------------------------------------------------------------------
// tb_data_uart_packetizer
//
// Bench for data_uart_packetizer with MAX_WORDS=2, GAP_CYCLES=4,
// VALID_TIMEOUT=8. A standard-read FIFO model feeds words, a UART model
// produces txBusy, and a negedge collector records every transmitted byte.
// A table of packet vectors is applied in a loop; timeout, reset-abort and a
// randomised scoreboard run follow as hand-written sequences.
// ----------------------------------------------------------------------------
module tb_data_uart_packetizer;

  localparam int RXN = 16384;
  localparam int FQN = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifoReady;
  logic        fifoValid;
  logic [15:0] fifoData;
  logic        fifoRead;
  logic        txBusy;
  logic        txStart;
  logic [7:0]  txData;
  logic        pktActive;
  logic        timeoutErr;

  data_uart_packetizer #(
    .MAX_WORDS    (2),
    .GAP_CYCLES   (4),
    .VALID_TIMEOUT(8),
    .HEADER       (8'hA5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fifoReady (fifoReady),
    .fifoValid (fifoValid),
    .fifoData  (fifoData),
    .fifoRead  (fifoRead),
    .txBusy    (txBusy),
    .txStart   (txStart),
    .txData    (txData),
    .pktActive (pktActive),
    .timeoutErr(timeoutErr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: standard read, data valid the cycle after fifoRead.
  logic [15:0] fmem [FQN];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        suppress = 1'b0;
  logic        inj_valid = 1'b0;
  logic        mvalid = 1'b0;
  logic [15:0] mdata = '0;

  assign fifoReady = (wr_ptr != rd_ptr);
  assign fifoValid = mvalid | inj_valid;
  assign fifoData  = inj_valid ? 16'hDEAD : mdata;

  always @(posedge clk) begin
    mvalid <= 1'b0;
    if (fifoRead && (wr_ptr != rd_ptr)) begin
      mdata  <= fmem[rd_ptr % FQN];
      mvalid <= !suppress;
      rd_ptr <= rd_ptr + 1;
    end
  end

  // UART model: busy from the cycle after txStart for a programmable length.
  int   busy_len = 1;
  logic busy_rand = 1'b0;
  int   busy_left = 0;
  assign txBusy = (busy_left != 0);

  always @(posedge clk) begin
    if (txStart)
      busy_left <= busy_rand ? int'($urandom_range(1, 3)) : busy_len;
    else if (busy_left > 0)
      busy_left <= busy_left - 1;
  end

  // Byte collector and protocol monitor.
  logic [7:0] rx [RXN];
  int         rx_cyc [RXN];
  int         rx_n = 0;
  int         rd_pulses = 0;
  int         last_rd_cyc = 0;
  int         mon_err = 0;
  logic       prev_start = 1'b0;
  logic       prev_read = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (txStart) begin
        rx[rx_n % RXN]     <= txData;
        rx_cyc[rx_n % RXN] <= cyc;
        rx_n               <= rx_n + 1;
        if (txBusy || prev_start) begin
          mon_err <= mon_err + 1;
          $display("protocol violation: txStart busy=%0b prev=%0b at cycle %0d", txBusy, prev_start, cyc);
        end
      end
      if (fifoRead) begin
        rd_pulses   <= rd_pulses + 1;
        last_rd_cyc <= cyc;
        if (!fifoReady || prev_read) begin
          mon_err <= mon_err + 1;
          $display("protocol violation: fifoRead ready=%0b prev=%0b at cycle %0d", fifoReady, prev_read, cyc);
        end
      end
    end
    prev_start <= txStart;
    prev_read  <= fifoRead;
  end

  int checks = 0;
  int errors = 0;
  int base = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] w);
    fmem[wr_ptr % FQN] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  // Wait until n bytes have arrived since base and the packet has closed.
  task automatic wait_frame(input string name, input int n, input int budget);
    int k = 0;
    while (((rx_n - base) < n || pktActive) && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= budget) begin
      errors++;
      $display("FAIL %s frame wait: got %0d bytes expected %0d within %0d cycles", name, rx_n - base, n, budget);
    end
  endtask

  typedef struct {
    int          nw;
    logic [15:0] w [3];
    int          busy;
    int          nb;
    logic [7:0]  b [12];
  } vec_t;

  localparam int NV = 5;
  vec_t vecs [NV];

  initial begin
    int rd0;
    int c0;
    int k;

    // Packet vectors: words pushed together, UART busy length, expected bytes.
    vecs[0].nw = 1; vecs[0].w = '{16'h1234, 16'h0, 16'h0}; vecs[0].busy = 1; vecs[0].nb = 5;
    vecs[0].b = '{8'hA5, 8'h12, 8'h34, 8'h01, 8'h27, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
    vecs[1].nw = 3; vecs[1].w = '{16'h0001, 16'h0002, 16'h0003}; vecs[1].busy = 2; vecs[1].nb = 12;
    vecs[1].b = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h02, 8'h02, 8'h01, 8'hA5, 8'h00, 8'h03, 8'h01, 8'h02};
    vecs[2].nw = 2; vecs[2].w = '{16'hFFFF, 16'h8001, 16'h0}; vecs[2].busy = 1; vecs[2].nb = 7;
    vecs[2].b = '{8'hA5, 8'hFF, 8'hFF, 8'h80, 8'h01, 8'h02, 8'h83, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
    vecs[3].nw = 1; vecs[3].w = '{16'h00A5, 16'h0, 16'h0}; vecs[3].busy = 3; vecs[3].nb = 5;
    vecs[3].b = '{8'hA5, 8'h00, 8'hA5, 8'h01, 8'hA4, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
    vecs[4].nw = 1; vecs[4].w = '{16'hBEEF, 16'h0, 16'h0}; vecs[4].busy = 20; vecs[4].nb = 5;
    vecs[4].b = '{8'hA5, 8'hBE, 8'hEF, 8'h01, 8'h50, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset fifoRead", fifoRead, 0);
    check("reset txStart", txStart, 0);
    check("reset txData", txData, 0);
    check("reset pktActive", pktActive, 0);
    check("reset timeoutErr", timeoutErr, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven packets
    for (int i = 0; i < NV; i++) begin
      busy_len = vecs[i].busy;
      @(negedge clk);
      base = rx_n;
      rd0  = rd_pulses;
      c0   = cyc;
      for (int j = 0; j < vecs[i].nw; j++) push(vecs[i].w[j]);
      wait_frame($sformatf("vec%0d", i), vecs[i].nb, 2000);
      repeat (3) @(negedge clk);
      for (int j = 0; j < vecs[i].nb; j++)
        check($sformatf("vec%0d byte%0d", i, j), rx[(base + j) % RXN], vecs[i].b[j]);
      check($sformatf("vec%0d byte count", i), rx_n - base, vecs[i].nb);
      check($sformatf("vec%0d read pulses", i), rd_pulses - rd0, vecs[i].nw);
      check($sformatf("vec%0d pktActive after", i), pktActive, 0);
      check($sformatf("vec%0d timeoutErr", i), timeoutErr, 0);
      check($sformatf("vec%0d protocol", i), mon_err, 0);
      if (i == 0) check("header latency", rx_cyc[base % RXN] - c0, 1);
    end

    // Read timeout: fifoValid withheld, late valid injected afterwards
    busy_len = 1;
    suppress = 1'b1;
    @(negedge clk);
    base = rx_n;
    rd0  = rd_pulses;
    push(16'h5555);
    k = 0;
    while (!timeoutErr && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("timeout raised", timeoutErr, 1);
    check("timeout delay", cyc - last_rd_cyc, 8);
    inj_valid = 1'b1;
    @(negedge clk);
    inj_valid = 1'b0;
    suppress  = 1'b0;
    wait_frame("timeout", 3, 200);
    repeat (3) @(negedge clk);
    check("timeout byte0", rx[base % RXN], 8'hA5);
    check("timeout byte1", rx[(base + 1) % RXN], 8'h00);
    check("timeout byte2", rx[(base + 2) % RXN], 8'h00);
    check("timeout byte count", rx_n - base, 3);
    check("timeout read pulses", rd_pulses - rd0, 1);

    base = rx_n;
    push(16'h0102);
    wait_frame("after timeout", 5, 200);
    repeat (3) @(negedge clk);
    check("post-timeout byte1", rx[(base + 1) % RXN], 8'h01);
    check("post-timeout byte2", rx[(base + 2) % RXN], 8'h02);
    check("post-timeout byte3", rx[(base + 3) % RXN], 8'h01);
    check("post-timeout csum", rx[(base + 4) % RXN], 8'h02);
    check("timeoutErr sticky", timeoutErr, 1);

    // Reset while waiting to send the low byte
    busy_len = 6;
    @(negedge clk);
    base = rx_n;
    push(16'h1234);
    k = 0;
    while ((rx_n - base) < 2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("abort bytes before reset", rx_n - base, 2);
    check("abort header", rx[base % RXN], 8'hA5);
    check("abort hi byte", rx[(base + 1) % RXN], 8'h12);
    check("abort pktActive before", pktActive, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset fifoRead", fifoRead, 0);
    check("async reset txStart", txStart, 0);
    check("async reset txData", txData, 0);
    check("async reset pktActive", pktActive, 0);
    check("async reset timeoutErr", timeoutErr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("no trailer after abort", rx_n - base, 2);
    base = rx_n;
    busy_len = 1;
    push(16'h00AB);
    wait_frame("after reset", 5, 300);
    repeat (3) @(negedge clk);
    check("fresh byte0", rx[base % RXN], 8'hA5);
    check("fresh byte1", rx[(base + 1) % RXN], 8'h00);
    check("fresh byte2", rx[(base + 2) % RXN], 8'hAB);
    check("fresh byte3", rx[(base + 3) % RXN], 8'h01);
    check("fresh csum", rx[(base + 4) % RXN], 8'hAA);

    // Randomised packets against a framing model
    busy_rand = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      logic [7:0]  exp [7];
      logic [7:0]  cs;
      logic [15:0] w;
      int          nw;
      int          ne;
      nw = int'($urandom_range(1, 2));
      @(negedge clk);
      base = rx_n;
      rd0  = rd_pulses;
      cs = 8'h00;
      exp[0] = 8'hA5;
      ne = 1;
      for (int j = 0; j < nw; j++) begin
        w = 16'($urandom);
        push(w);
        exp[ne] = w[15:8]; cs = cs ^ w[15:8]; ne++;
        exp[ne] = w[7:0];  cs = cs ^ w[7:0];  ne++;
      end
      exp[ne] = 8'(nw); cs = cs ^ 8'(nw); ne++;
      exp[ne] = cs; ne++;
      wait_frame($sformatf("rand%0d", p), ne, 400);
      for (int j = 0; j < ne; j++)
        check($sformatf("rand%0d byte%0d", p, j), rx[(base + j) % RXN], exp[j]);
      check($sformatf("rand%0d read pulses", p), rd_pulses - rd0, nw);
    end
    repeat (5) @(negedge clk);
    check("random protocol", mon_err, 0);
    check("random timeoutErr", timeoutErr, 0);
    check("fifo drained", rd_ptr, wr_ptr);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
